multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Multicycle control FSM that sits directly upstream of the CPU datapath.
//  - Sequences FETCH/DECODE/EXEC/MEM/BRANCH for each instruction.
//  - Drives every datapath enable, mux select and ALU code.
//  - Holds the processor flag register and evaluates branch conditions.
//  - Handshakes with memory through memRead/memWrite/mem_ready.
// PARAMETERS
//  WAIT_LIMIT  8  max cycles waiting on mem_ready before entering FAULT (1..255)
// PORTS
//  clk            in   1   system clock, rising edge
//  reset          in   1   asynchronous, active-low reset
//  instruction    in   16  word on memory read bus (OpCode[15:12] Rdest[11:8] Ext[7:4] Rsrc[3:0])
//  mem_ready      in   1   memory completes current read/write this cycle
//  C,L,F,Z,N      in   1   ALU flags from datapath, valid in EXEC
//  irS            out  1   instruction-register latch strobe
//  srcRegEn,dstRegEn,immRegEn out 1 operand-register loads
//  regFileEn      out  1   register-file write enable
//  signEn         out  1   sign-extend (1) / zero-extend (0) immediate
//  mux4En         out  2   ALU A select: 00 reg, 01 imm, 10 const 1
//  exMemResultEn  out  2   writeback select: 00 ALU/shift, 01 memdata, 10 A operand (MOV)
//  shiftALUMuxEn,regImmMuxEn out 1 shift-vs-ALU, shift amount reg-vs-imm
//  regpcCont      out  2   address mux select (00 = Rsrc data)
//  aluControl     out  4   ALU operation code
//  memRead,memWrite out 1  memory request strobes, held until mem_ready
//  pcRegEn        out  1   PC update pulse; pcLoad selects load vs increment
//  pcLoad         out  1   1 = load PC from pcSrc target, 0 = PC+1
//  pcSrc          out  1   0 = PC+sext(imm8), 1 = Rsrc data
//  fault          out  1   sticky memory-timeout indicator
// BEHAVIOUR
//  - Reset (reset=0, async): state=FETCH, flags=0, wait counter=0; every output 0.
//  - All outputs are registered-state decodes; no output depends combinationally on mem_ready except irS/regFileEn.
//  - FETCH: memRead=1. On mem_ready: irS=1 same cycle, go DECODE.
//  - DECODE (1 cycle): srcRegEn=dstRegEn=immRegEn=1; next state from OpCode/Ext:
//    * 0000 R-type, imm-type (0001,0010,0011,0101,1001,1011,1101), 1000 shift -> EXEC
//    * 0100 Ext 0000 LOAD / 0100 STOR -> MEM
//    * 1100 Bcond, 0100 Ext 1100 Jcond -> BRANCH
//    * any other encoding -> NOP: pcRegEn=1 with pcLoad=0 on the following FETCH entry.
//  - EXEC (1 cycle): aluControl=Ext for R-type, OpCode for imm-type.
//    * mux4En=01 for imm-type; signEn=1 except AND/OR/XOR imm (zero-extend).
//    * Shift: shiftALUMuxEn=1, regImmMuxEn=Ext[0]==0.
//    * MOV/MOVI: exMemResultEn=10.
//    * regFileEn=1 except CMP/CMPI.
//    * Flags latched from C,L,F,Z,N for ADD/SUB/CMP (reg and imm) only.
//    * pcRegEn=1, pcLoad=0; -> FETCH.
//  - MEM: regpcCont=00; LOAD memRead=1, STOR memWrite=1, held until mem_ready.
//    On mem_ready: LOAD regFileEn=1 with exMemResultEn=01; pcRegEn=1; -> FETCH.
//  - BRANCH (1 cycle): cond=Rdest field.
//    * Codes: 0000 EQ Z, 0001 NE !Z, 0010 CS C, 0011 CC !C, 0100 HI L, 0101 LS !L,
//      0110 GT N, 0111 LE !N, 1000 FS F, 1001 FC !F, 1110 UC always; others never taken.
//    * pcRegEn=1, pcLoad=taken, pcSrc=1 for Jcond; -> FETCH.
//  - Wait counter: counts cycles in FETCH/MEM without mem_ready, cleared on ready.
//    Reaching WAIT_LIMIT: drop strobes, assert fault, enter FAULT; only reset exits.
//  - mem_ready outside FETCH/MEM ignored. Reset mid-access abandons it; no write completes.
//  - Latency: ALU/branch = 3 cycles, memory op = 4 + wait cycles, fetch waits included.
// CONFIGURATION
//  CTRL_PERF_CNT_EN defined:
//   - Adds output instRetired[15:0]: +1 on each pcRegEn pulse, wraps FFFF->0000, reset 0.
//  Undefined: port and counter absent; all other behaviour identical.
// TESTING
//  - ADD R1,R2 (0x0152), ready in 1st fetch cycle -> regFileEn in EXEC, aluControl=0101, pcRegEn on 3rd cycle.
//  - CMPI R3,#-1 (0xB3FF) then BEQ (0xC0xx) with Z=1 -> regFileEn=0, signEn=1, pcLoad=1, pcSrc=0.
//  - LOAD (0x4201) with mem_ready after 3 stall cycles -> memRead held 3 cycles, exMemResultEn=01, regFileEn on ready cycle.
//  - mem_ready never asserted in FETCH with WAIT_LIMIT=8 -> fault=1 after 8 cycles, memRead=0, stays until reset.
//  - reset pulled low during STOR wait -> memWrite=0 immediately, state FETCH, flags 0.
//  - CTRL_PERF_CNT_EN, 65537 retired NOPs -> instRetired=0001.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Control and handshake bundle between the multicycle controller (master)
// and the CPU datapath / memory side (slave).
interface multicycle_controller_if;
    // Memory read bus and handshake
    logic [15:0] instruction;
    logic        mem_ready;
    logic        memRead;
    logic        memWrite;

    // ALU flags from the datapath, valid while the controller is in EXEC
    logic        C;
    logic        L;
    logic        F;
    logic        Z;
    logic        N;

    // Datapath enables, mux selects and ALU code
    logic        irS;
    logic        srcRegEn;
    logic        dstRegEn;
    logic        immRegEn;
    logic        regFileEn;
    logic        signEn;
    logic [1:0]  mux4En;
    logic [1:0]  exMemResultEn;
    logic        shiftALUMuxEn;
    logic        regImmMuxEn;
    logic [1:0]  regpcCont;
    logic [3:0]  aluControl;
    logic        pcRegEn;
    logic        pcLoad;
    logic        pcSrc;
    logic        fault;

    modport master (
        input  instruction, mem_ready, C, L, F, Z, N,
        output memRead, memWrite, irS, srcRegEn, dstRegEn, immRegEn,
               regFileEn, signEn, mux4En, exMemResultEn, shiftALUMuxEn,
               regImmMuxEn, regpcCont, aluControl, pcRegEn, pcLoad, pcSrc,
               fault
    );

    modport slave (
        output instruction, mem_ready, C, L, F, Z, N,
        input  memRead, memWrite, irS, srcRegEn, dstRegEn, immRegEn,
               regFileEn, signEn, mux4En, exMemResultEn, shiftALUMuxEn,
               regImmMuxEn, regpcCont, aluControl, pcRegEn, pcLoad, pcSrc,
               fault
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle CPU control FSM: sequences FETCH/DECODE/EXEC/MEM/BRANCH, drives
// every datapath control, owns the flag register and evaluates branch
// conditions. A memory access that waits WAIT_LIMIT cycles without mem_ready
// parks the controller in a sticky FAULT state.
// Optional feature: define CTRL_PERF_CNT_EN to add the 16-bit instRetired
// counter output (one count per pcRegEn pulse, wrapping).
module multicycle_controller #(
    parameter int WAIT_LIMIT = 8  // 1..255
) (
    input  logic                    clk,
    input  logic                    reset,   // asynchronous, active-low
    multicycle_controller_if.master bus
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [15:0]             instRetired
`endif
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_BRANCH,
        S_FAULT
    } state_t;

    typedef struct packed {
        logic c;
        logic l;
        logic f;
        logic z;
        logic n;
    } flags_t;

    state_t     state;
    state_t     state_next;

    // Controller's own copy of OpCode/Rdest/Ext; Rsrc only matters to the datapath
    logic [11:0] ir;
    flags_t      flags;
    logic [7:0]  wait_cnt;
    // A MEM completion or a NOP owes the PC an increment on the next FETCH entry
    logic        pc_pending;
    logic [3:0]  unused_rsrc;

    logic [3:0]  opcode;
    logic [3:0]  rdest;
    logic [3:0]  ext;
    logic [3:0]  alu_code;
    logic        is_rtype;
    logic        is_imm;
    logic        is_logic_imm;
    logic        is_shift;
    logic        is_load;
    logic        is_stor;
    logic        is_bcond;
    logic        is_jcond;
    logic        is_alu;
    logic        is_cmp;
    logic        is_mov;
    logic        is_flag_op;
    logic        decode_nop;
    logic        taken;
    logic        mem_phase;
    logic        wait_expired;

    assign unused_rsrc  = bus.instruction[3:0];

    assign opcode       = ir[11:8];
    assign rdest        = ir[7:4];
    assign ext          = ir[3:0];

    assign is_rtype     = (opcode == 4'h0);
    assign is_imm       = opcode inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD};
    assign is_logic_imm = opcode inside {4'h1, 4'h2, 4'h3};
    assign is_shift     = (opcode == 4'h8);
    assign is_load      = (opcode == 4'h4) && (ext == 4'h0);
    assign is_stor      = (opcode == 4'h4) && (ext == 4'h4);
    assign is_jcond     = (opcode == 4'h4) && (ext == 4'hC);
    assign is_bcond     = (opcode == 4'hC);

    // R-type carries the ALU operation in Ext, immediate forms in OpCode
    assign alu_code     = is_rtype ? ext : opcode;
    assign is_alu       = is_rtype || is_imm;
    assign is_cmp       = is_alu && (alu_code == 4'hB);
    assign is_mov       = is_alu && (alu_code == 4'hD);
    assign is_flag_op   = is_alu && (alu_code inside {4'h5, 4'h9, 4'hB});
    assign decode_nop   = !(is_alu || is_shift || is_load || is_stor ||
                            is_bcond || is_jcond);

    assign mem_phase    = (state == S_FETCH) || (state == S_MEM);
    assign wait_expired = mem_phase && !bus.mem_ready &&
                          (wait_cnt == 8'(WAIT_LIMIT - 1));

    // Branch condition evaluation against the latched flag register
    always_comb begin
        case (rdest)
            4'h0:    taken = flags.z;
            4'h1:    taken = !flags.z;
            4'h2:    taken = flags.c;
            4'h3:    taken = !flags.c;
            4'h4:    taken = flags.l;
            4'h5:    taken = !flags.l;
            4'h6:    taken = flags.n;
            4'h7:    taken = !flags.n;
            4'h8:    taken = flags.f;
            4'h9:    taken = !flags.f;
            4'hE:    taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    // State register
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_FETCH;
        else        state <= state_next;
    end

    // Next-state selection
    always_comb begin
        state_next = state;
        case (state)
            S_FETCH: begin
                if (bus.mem_ready)      state_next = S_DECODE;
                else if (wait_expired)  state_next = S_FAULT;
            end
            S_DECODE: begin
                if (is_alu || is_shift)        state_next = S_EXEC;
                else if (is_load || is_stor)   state_next = S_MEM;
                else if (is_bcond || is_jcond) state_next = S_BRANCH;
                else                           state_next = S_FETCH;
            end
            S_EXEC:   state_next = S_FETCH;
            S_BRANCH: state_next = S_FETCH;
            S_MEM: begin
                if (bus.mem_ready)      state_next = S_FETCH;
                else if (wait_expired)  state_next = S_FAULT;
            end
            S_FAULT:  state_next = S_FAULT;
            default:  state_next = S_FETCH;
        endcase
    end

    // Instruction copy, flag register, memory wait counter and deferred PC step
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir         <= '0;
            flags      <= '0;
            wait_cnt   <= '0;
            pc_pending <= 1'b0;
        end else begin
            if (state == S_FETCH && bus.mem_ready)
                ir <= bus.instruction[15:4];
            if (state == S_EXEC && is_flag_op)
                flags <= '{c: bus.C, l: bus.L, f: bus.F, z: bus.Z, n: bus.N};
            wait_cnt   <= (mem_phase && !bus.mem_ready) ? wait_cnt + 8'd1 : 8'd0;
            pc_pending <= (state == S_DECODE && decode_nop) ||
                          (state == S_MEM && bus.mem_ready);
        end
    end

    // Output decode; everything is held at 0 while reset is asserted so an
    // in-flight memory strobe drops the moment reset falls
    always_comb begin
        // NOTE: every output gets a default before the case so no path can
        // leave one unassigned and infer a latch.
        bus.irS           = 1'b0;
        bus.srcRegEn      = 1'b0;
        bus.dstRegEn      = 1'b0;
        bus.immRegEn      = 1'b0;
        bus.regFileEn     = 1'b0;
        bus.signEn        = 1'b0;
        bus.mux4En        = 2'b00;
        bus.exMemResultEn = 2'b00;
        bus.shiftALUMuxEn = 1'b0;
        bus.regImmMuxEn   = 1'b0;
        bus.regpcCont     = 2'b00;
        bus.aluControl    = 4'h0;
        bus.memRead       = 1'b0;
        bus.memWrite      = 1'b0;
        bus.pcRegEn       = 1'b0;
        bus.pcLoad        = 1'b0;
        bus.pcSrc         = 1'b0;
        bus.fault         = 1'b0;
        if (reset) begin
            case (state)
                S_FETCH: begin
                    bus.memRead = 1'b1;
                    bus.irS     = bus.mem_ready;
                    bus.pcRegEn = pc_pending;
                end
                S_DECODE: begin
                    bus.srcRegEn = 1'b1;
                    bus.dstRegEn = 1'b1;
                    bus.immRegEn = 1'b1;
                end
                S_EXEC: begin
                    bus.pcRegEn   = 1'b1;
                    bus.signEn    = !is_logic_imm;
                    bus.regFileEn = !is_cmp;
                    if (is_shift) begin
                        bus.shiftALUMuxEn = 1'b1;
                        bus.regImmMuxEn   = !ext[0];
                    end else begin
                        bus.aluControl    = alu_code;
                        bus.mux4En        = is_imm ? 2'b01 : 2'b00;
                        bus.exMemResultEn = is_mov ? 2'b10 : 2'b00;
                    end
                end
                S_MEM: begin
                    bus.regpcCont     = 2'b00;
                    bus.memRead       = is_load;
                    bus.memWrite      = is_stor;
                    bus.exMemResultEn = is_load ? 2'b01 : 2'b00;
                    bus.regFileEn     = is_load && bus.mem_ready;
                end
                S_BRANCH: begin
                    bus.pcRegEn = 1'b1;
                    bus.pcLoad  = taken;
                    bus.pcSrc   = is_jcond;
                end
                S_FAULT: bus.fault = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef CTRL_PERF_CNT_EN
    // Retired-instruction counter: one count per PC update, wraps naturally
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)           instRetired <= '0;
        else if (bus.pcRegEn) instRetired <= instRetired + 16'd1;
    end
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: reset, EXEC decode table,
// branch-condition table, randomized instruction stream against a
// per-instruction reference model, memory stalls, timeout fault and reset
// during a store.
module tb_multicycle_controller;

    localparam int WAIT_LIMIT = 8;

    typedef struct packed {
        logic       irs;
        logic       src;
        logic       dst;
        logic       imm;
        logic       rfe;
        logic       sgn;
        logic [1:0] mux4;
        logic [1:0] emr;
        logic       sh;
        logic       rim;
        logic [1:0] rpc;
        logic [3:0] alu;
        logic       mrd;
        logic       mwr;
        logic       pce;
        logic       pcl;
        logic       pcs;
        logic       flt;
    } ctl_t;

    typedef struct packed {
        logic c;
        logic l;
        logic f;
        logic z;
        logic n;
    } flags_t;

    typedef enum {K_EXEC, K_LOAD, K_STOR, K_BRANCH, K_NOP} kind_t;

    typedef struct {
        logic [15:0] ins;
        logic [3:0]  alu;
        logic [1:0]  mux4;
        logic        sgn;
        logic        rfe;
        logic [1:0]  emr;
        logic        sh;
        logic        rim;
    } exec_vec_t;

    typedef struct {
        flags_t      fl;
        logic [15:0] ins;
        logic        pcl;
        logic        pcs;
    } br_vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multicycle_controller_if bus ();

`ifdef CTRL_PERF_CNT_EN
    logic [15:0] inst_retired;
`endif

    multicycle_controller #(.WAIT_LIMIT(WAIT_LIMIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef CTRL_PERF_CNT_EN
        ,
        .instRetired (inst_retired)
`endif
    );

    int     errors = 0;
    int     checks = 0;

    // Reference model state
    flags_t m_flags;
    logic   m_pend;
    int     m_retired;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic ctl_t sample();
        ctl_t s;
        s.irs  = bus.irS;
        s.src  = bus.srcRegEn;
        s.dst  = bus.dstRegEn;
        s.imm  = bus.immRegEn;
        s.rfe  = bus.regFileEn;
        s.sgn  = bus.signEn;
        s.mux4 = bus.mux4En;
        s.emr  = bus.exMemResultEn;
        s.sh   = bus.shiftALUMuxEn;
        s.rim  = bus.regImmMuxEn;
        s.rpc  = bus.regpcCont;
        s.alu  = bus.aluControl;
        s.mrd  = bus.memRead;
        s.mwr  = bus.memWrite;
        s.pce  = bus.pcRegEn;
        s.pcl  = bus.pcLoad;
        s.pcs  = bus.pcSrc;
        s.flt  = bus.fault;
        return s;
    endfunction

    function automatic flags_t rand_flags();
        logic [4:0] r;
        r = 5'($urandom);
        return flags_t'(r);
    endfunction

    function automatic logic rand_bit();
        return 1'($urandom);
    endfunction

    // Instruction class from the opcode map
    function automatic kind_t classify(input logic [15:0] ins);
        logic [3:0] op;
        logic [3:0] ext;
        op  = ins[15:12];
        ext = ins[7:4];
        case (op)
            4'h0, 4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD, 4'h8: return K_EXEC;
            4'hC: return K_BRANCH;
            4'h4: begin
                if (ext == 4'h0)      return K_LOAD;
                else if (ext == 4'h4) return K_STOR;
                else if (ext == 4'hC) return K_BRANCH;
                else                  return K_NOP;
            end
            default: return K_NOP;
        endcase
    endfunction

    // Whether an ALU instruction updates the flag register (ADD/SUB/CMP, reg or imm)
    function automatic logic sets_flags(input logic [15:0] ins);
        if (ins[15:12] == 4'h0) return ins[7:4] inside {4'h5, 4'h9, 4'hB};
        return ins[15:12] inside {4'h5, 4'h9, 4'hB};
    endfunction

    // Controls expected in the EXEC cycle of an ALU or shift instruction
    function automatic ctl_t expect_exec(input logic [15:0] ins);
        ctl_t       e;
        logic [3:0] op;
        logic [3:0] ext;
        logic [3:0] code;
        op   = ins[15:12];
        ext  = ins[7:4];
        code = (op == 4'h0) ? ext : op;
        e     = '0;
        e.pce = 1'b1;
        e.sgn = !(op inside {4'h1, 4'h2, 4'h3});
        if (op == 4'h8) begin
            e.sh  = 1'b1;
            e.rim = !ext[0];
            e.rfe = 1'b1;
        end else begin
            e.alu  = code;
            e.mux4 = (op == 4'h0) ? 2'b00 : 2'b01;
            e.emr  = (code == 4'hD) ? 2'b10 : 2'b00;
            e.rfe  = (code != 4'hB);
        end
        return e;
    endfunction

    function automatic logic branch_taken(input logic [3:0] cond, input flags_t f);
        case (cond)
            4'h0:    return f.z;
            4'h1:    return !f.z;
            4'h2:    return f.c;
            4'h3:    return !f.c;
            4'h4:    return f.l;
            4'h5:    return !f.l;
            4'h6:    return f.n;
            4'h7:    return !f.n;
            4'h8:    return f.f;
            4'h9:    return !f.f;
            4'hE:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // One clock: called at a falling edge, drives inputs, checks, ends at the next falling edge
    task automatic cycle(input logic [15:0] ins, input logic ready, input flags_t fl,
                         input ctl_t exp, input string name, output ctl_t seen);
        bus.instruction = ins;
        bus.mem_ready   = ready;
        bus.C = fl.c; bus.L = fl.l; bus.F = fl.f; bus.Z = fl.z; bus.N = fl.n;
        #1;
        seen = sample();
        check(name, 32'(seen), 32'(exp));
        @(negedge clk);
    endtask

    // Runs one whole instruction, checking every cycle against the model;
    // returns what was seen in the EXEC/BRANCH cycle
    task automatic run_instr(input logic [15:0] ins, input int fstall, input int mstall,
                             input flags_t fl, output ctl_t seen);
        ctl_t  e;
        ctl_t  s;
        kind_t k;
        seen = '0;
        k = classify(ins);
        for (int i = 0; i <= fstall; i++) begin
            e     = '0;
            e.mrd = 1'b1;
            e.irs = (i == fstall);
            e.pce = (i == 0) && m_pend;
            if (i == 0 && m_pend) m_retired++;
            cycle((i == fstall) ? ins : 16'($urandom), i == fstall, rand_flags(), e, "fetch", s);
        end
        m_pend = 1'b0;
        e     = '0;
        e.src = 1'b1;
        e.dst = 1'b1;
        e.imm = 1'b1;
        cycle(16'($urandom), rand_bit(), rand_flags(), e, "decode", s);
        case (k)
            K_EXEC: begin
                cycle(16'($urandom), rand_bit(), fl, expect_exec(ins), "exec", seen);
                if (sets_flags(ins)) m_flags = fl;
                m_retired++;
            end
            K_BRANCH: begin
                e     = '0;
                e.pce = 1'b1;
                e.pcl = branch_taken(ins[11:8], m_flags);
                e.pcs = (ins[15:12] == 4'h4);
                cycle(16'($urandom), rand_bit(), rand_flags(), e, "branch", seen);
                m_retired++;
            end
            K_LOAD, K_STOR: begin
                for (int j = 0; j <= mstall; j++) begin
                    e     = '0;
                    e.mrd = (k == K_LOAD);
                    e.mwr = (k == K_STOR);
                    e.emr = (k == K_LOAD) ? 2'b01 : 2'b00;
                    e.rfe = (k == K_LOAD) && (j == mstall);
                    cycle(16'($urandom), j == mstall, rand_flags(), e, "mem", s);
                end
                m_pend = 1'b1;
            end
            default: m_pend = 1'b1;
        endcase
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        check("reset_outputs", 32'(sample()), 32'h0);
        repeat (2) @(negedge clk);
        reset     = 1'b1;
        m_flags   = '0;
        m_pend    = 1'b0;
        m_retired = 0;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish by %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        exec_vec_t ev[12];
        br_vec_t   bv[11];
        ctl_t      s;
        ctl_t      e;
        int        fs;
        int        ms;

        ev[0]  = '{16'h0152, 4'h5, 2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0}; // ADD R1,R2
        ev[1]  = '{16'h00B3, 4'hB, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0}; // CMP
        ev[2]  = '{16'h00D3, 4'hD, 2'b00, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0}; // MOV
        ev[3]  = '{16'h1312, 4'h1, 2'b01, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0}; // ANDI
        ev[4]  = '{16'h2312, 4'h2, 2'b01, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0}; // ORI
        ev[5]  = '{16'h3312, 4'h3, 2'b01, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0}; // XORI
        ev[6]  = '{16'h5312, 4'h5, 2'b01, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0}; // ADDI
        ev[7]  = '{16'h9312, 4'h9, 2'b01, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0}; // SUBI
        ev[8]  = '{16'hB3FF, 4'hB, 2'b01, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0}; // CMPI R3,#-1
        ev[9]  = '{16'hD312, 4'hD, 2'b01, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0}; // MOVI
        ev[10] = '{16'h8302, 4'h0, 2'b00, 1'b1, 1'b1, 2'b00, 1'b1, 1'b1}; // shift by reg
        ev[11] = '{16'h8312, 4'h0, 2'b00, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0}; // shift by imm

        //             {c,l,f,z,n}
        bv[0]  = '{5'b00010, 16'hC005, 1'b1, 1'b0}; // EQ, Z=1
        bv[1]  = '{5'b00000, 16'hC005, 1'b0, 1'b0}; // EQ, Z=0
        bv[2]  = '{5'b00000, 16'hC105, 1'b1, 1'b0}; // NE
        bv[3]  = '{5'b10000, 16'hC2F0, 1'b1, 1'b0}; // CS
        bv[4]  = '{5'b10111, 16'hC400, 1'b0, 1'b0}; // HI with L=0
        bv[5]  = '{5'b00000, 16'hC700, 1'b1, 1'b0}; // LE
        bv[6]  = '{5'b00100, 16'hC800, 1'b1, 1'b0}; // FS
        bv[7]  = '{5'b00000, 16'hCE00, 1'b1, 1'b0}; // UC
        bv[8]  = '{5'b11111, 16'hCA00, 1'b0, 1'b0}; // undefined code never taken
        bv[9]  = '{5'b00010, 16'h4EC2, 1'b1, 1'b1}; // Jcond UC
        bv[10] = '{5'b00000, 16'h40C3, 1'b0, 1'b1}; // Jcond EQ, Z=0

        bus.instruction = '0;
        bus.mem_ready   = 1'b0;
        bus.C = 1'b0; bus.L = 1'b0; bus.F = 1'b0; bus.Z = 1'b0; bus.N = 1'b0;
        reset = 1'b1;
        #1;
        do_reset();

        // EXEC decode table
        for (int i = 0; i < 12; i++) begin
            run_instr(ev[i].ins, 0, 0, rand_flags(), s);
            e      = '0;
            e.pce  = 1'b1;
            e.alu  = ev[i].alu;
            e.mux4 = ev[i].mux4;
            e.sgn  = ev[i].sgn;
            e.rfe  = ev[i].rfe;
            e.emr  = ev[i].emr;
            e.sh   = ev[i].sh;
            e.rim  = ev[i].rim;
            check($sformatf("exec_tbl[%0d]", i), 32'(s), 32'(e));
        end

        // Branch condition table: ADD latches the flags, then the branch
        for (int i = 0; i < 11; i++) begin
            run_instr(16'h0152, 0, 0, bv[i].fl, s);
            run_instr(bv[i].ins, 0, 0, rand_flags(), s);
            check($sformatf("branch_tbl[%0d]", i), 32'({s.pcl, s.pcs}), 32'({bv[i].pcl, bv[i].pcs}));
        end

        // CMPI R3,#-1 with Z=1 followed by BEQ
        run_instr(16'hB3FF, 0, 0, 5'b00010, s);
        run_instr(16'hC012, 0, 0, rand_flags(), s);
        check("cmpi_beq_taken", 32'({s.pcl, s.pcs}), 32'b10);

        // LOAD with three stall cycles, then fetch and memory stalls just under the limit
        run_instr(16'h4201, 0, 3, rand_flags(), s);
        run_instr(16'h4201, WAIT_LIMIT - 1, WAIT_LIMIT - 1, rand_flags(), s);
        run_instr(16'h4340, 2, WAIT_LIMIT - 1, rand_flags(), s);
        run_instr(16'h6000, 0, 0, rand_flags(), s); // NOP
        run_instr(16'h0152, 1, 0, rand_flags(), s);

        // Randomized instruction stream
        for (int n = 0; n < 300; n++) begin
            fs = ($urandom_range(0, 7) == 0) ? WAIT_LIMIT - 1 : $urandom_range(0, 2);
            ms = ($urandom_range(0, 7) == 0) ? WAIT_LIMIT - 1 : $urandom_range(0, 2);
            run_instr(16'($urandom), fs, ms, rand_flags(), s);
        end

`ifdef CTRL_PERF_CNT_EN
        run_instr(16'h0152, 0, 0, rand_flags(), s);
        check("inst_retired", 32'(inst_retired), 32'(16'(m_retired)));
`endif

        // Reset in the middle of a STOR wait; flags set by CMP with Z=1 must clear
        run_instr(16'h00B0, 0, 0, 5'b00010, s);
        e     = '0;
        e.mrd = 1'b1;
        e.irs = 1'b1;
        cycle(16'h4140, 1'b1, rand_flags(), e, "stor_fetch", s);
        e     = '0;
        e.src = 1'b1;
        e.dst = 1'b1;
        e.imm = 1'b1;
        cycle(16'($urandom), 1'b0, rand_flags(), e, "stor_decode", s);
        e     = '0;
        e.mwr = 1'b1;
        bus.mem_ready = 1'b0;
        #1;
        check("stor_wait", 32'(sample()), 32'(e));
        #1;
        do_reset();
        run_instr(16'hC000, 0, 0, rand_flags(), s);
        check("beq_after_reset", 32'(s.pcl), 32'b0);
        run_instr(16'hC100, 0, 0, rand_flags(), s);
        check("bne_after_reset", 32'(s.pcl), 32'b1);

        // Fetch that never sees mem_ready: WAIT_LIMIT cycles of memRead, then sticky fault
        for (int i = 0; i < WAIT_LIMIT; i++) begin
            e     = '0;
            e.mrd = 1'b1;
            e.pce = (i == 0) && m_pend;
            cycle(16'($urandom), 1'b0, rand_flags(), e, "fault_wait", s);
        end
        m_pend = 1'b0;
        for (int i = 0; i < 6; i++) begin
            e     = '0;
            e.flt = 1'b1;
            cycle(16'($urandom), rand_bit(), rand_flags(), e, "fault_sticky", s);
        end
        do_reset();
        run_instr(16'h0152, 0, 0, rand_flags(), s);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
